// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Sequencing front end for a 32-bit combinational ALU. It accepts one MIPS
// R-type operation per valid/ready handshake and decodes funct into an ALU
// opcode and operands. It registers the operands and drives them to the ALU.
// It captures the ALU result one cycle later and presents it on a
// valid/ready output port.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/ready    request handshake (funct, shamt, rs_val, rt_val)
//   alu_a/b/op        registered operands/opcode driven to the ALU
//   alu_c             ALU result, combinational from alu_a/alu_b/alu_op
//   out_valid/ready   result handshake (out_result, out_illegal)
//   busy              high whenever the controller is not idle
//
// Optional feature macro: ALU_ISSUE_BYPASS_EN
//   When this macro is defined, a new request can be accepted in HOLD in the
//   same cycle that the result is consumed. This gives one operation every
//   two cycles. When it is undefined, HOLD always returns to IDLE first.

module alu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_c,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SRL = 3'd4;
  localparam logic [2:0] OP_SRA = 3'd5;

  state_t      state, state_nxt;
  logic        alive;
  logic        illegal_q;
  logic        dec_illegal;
  logic [2:0]  dec_op;
  logic [31:0] dec_a, dec_b;
  logic        accept;
  logic        out_fire;

  // Decode funct. Shift amounts are zero-extended from 5 bits, so the ALU
  // never sees a B operand above 31. An unsupported funct produces
  // all-zero operands and sets the illegal flag.
  always_comb begin
    dec_illegal = 1'b0;
    dec_op      = OP_ADD;
    dec_a       = rs_val;
    dec_b       = rt_val;
    case (funct)
      6'h21: dec_op = OP_ADD;
      6'h23: dec_op = OP_SUB;
      6'h24: dec_op = OP_AND;
      6'h25: dec_op = OP_OR;
      6'h02: begin
        dec_op = OP_SRL;
        dec_a  = rt_val;
        dec_b  = {27'b0, shamt};
      end
      6'h03: begin
        dec_op = OP_SRA;
        dec_a  = rt_val;
        dec_b  = {27'b0, shamt};
      end
      6'h06: begin
        dec_op = OP_SRL;
        dec_a  = rt_val;
        dec_b  = {27'b0, rs_val[4:0]};
      end
      6'h07: begin
        dec_op = OP_SRA;
        dec_a  = rt_val;
        dec_b  = {27'b0, rs_val[4:0]};
      end
      default: begin
        dec_illegal = 1'b1;
        dec_a       = 32'd0;
        dec_b       = 32'd0;
      end
    endcase
  end

  // The alive flag keeps in_ready low while reset is asserted. It also keeps
  // in_ready low until the first clock edge after reset is released.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      IDLE: in_ready = alive;
`ifdef ALU_ISSUE_BYPASS_EN
      HOLD: in_ready = alive && out_ready;
`endif
      default: in_ready = 1'b0;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != IDLE);

  // Next-state logic. An accept in HOLD is only possible with the bypass
  // feature enabled. In that case the controller goes straight back to EXEC.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = HOLD;
      HOLD: if (out_fire) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alive       <= 1'b0;
      alu_a       <= 32'd0;
      alu_b       <= 32'd0;
      alu_op      <= 3'd0;
      illegal_q   <= 1'b0;
      out_valid   <= 1'b0;
      out_result  <= 32'd0;
      out_illegal <= 1'b0;
    end else begin
      alive <= 1'b1;
      state <= state_nxt;
      if (accept) begin
        alu_a     <= dec_a;
        alu_b     <= dec_b;
        alu_op    <= dec_op;
        illegal_q <= dec_illegal;
      end
      // The ALU has settled on the registered operands by the end of EXEC.
      if (state == EXEC) begin
        out_result  <= illegal_q ? 32'd0 : alu_c;
        out_illegal <= illegal_q;
        out_valid   <= 1'b1;
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. The bench contains a behavioural
// model of the 32-bit ALU that closes the alu_a/alu_b/alu_op -> alu_c loop.
// Every expected value below is a hand-computed constant.
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_illegal;
  logic        busy;

  int checks = 0;
  int errors = 0;

`ifdef ALU_ISSUE_BYPASS_EN
  localparam int EXP_SPACING = 2;
`else
  localparam int EXP_SPACING = 3;
`endif

  alu_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .funct      (funct),
    .shamt      (shamt),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_c      (alu_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_illegal(out_illegal),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ALU model.
  always_comb begin
    alu_c = 32'd0;
    case (alu_op)
      3'd0: alu_c = alu_a + alu_b;
      3'd1: alu_c = alu_a - alu_b;
      3'd2: alu_c = alu_a & alu_b;
      3'd3: alu_c = alu_a | alu_b;
      3'd4: alu_c = alu_a >> alu_b[4:0];
      3'd5: alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_c = 32'd0;
    endcase
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Outputs are sampled 1 time unit after each rising edge. Inputs are
  // driven at the same point, so they are stable for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request and wait, with a bound, until an edge consumes it.
  // On return the sample point is just after the accepting edge, so the
  // controller is in EXEC.
  task automatic applyStimulus(input logic [5:0] f, input logic [4:0] sa,
                               input logic [31:0] rs, input logic [31:0] rt);
    logic got;
    funct    = f;
    shamt    = sa;
    rs_val   = rs;
    rt_val   = rt;
    in_valid = 1'b1;
    got      = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = in_ready;
      step();
    end
    in_valid = 1'b0;
    checkOutput("accept", {31'b0, got}, 32'd1);
  endtask

  initial begin
    logic [31:0] first_res;
    logic        got_first;
    logic        got;
    int          acc0;
    int          acc1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    funct     = 6'h00;
    shamt     = 5'd0;
    rs_val    = 32'd0;
    rt_val    = 32'd0;
    out_ready = 1'b1;

    // Reset state while reset is held.
    #12;
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_result", out_result, 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    #11 rst_n = 1'b1;
    step();
    checkOutput("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // addu 0xFFFFFFFF + 2 wraps to 1.
    applyStimulus(6'h21, 5'd0, 32'hFFFF_FFFF, 32'h0000_0002);
    checkOutput("addu_alu_op", {29'b0, alu_op}, 32'd0);
    checkOutput("addu_alu_b", alu_b, 32'h0000_0002);
    checkOutput("addu_busy", {31'b0, busy}, 32'd1);
    checkOutput("addu_in_ready_exec", {31'b0, in_ready}, 32'd0);
    checkOutput("addu_valid_early", {31'b0, out_valid}, 32'd0);
    step();
    checkOutput("addu_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("addu_result", out_result, 32'h0000_0001);
    checkOutput("addu_illegal", {31'b0, out_illegal}, 32'd0);
    step();
    checkOutput("addu_valid_clear", {31'b0, out_valid}, 32'd0);
    checkOutput("addu_idle", {31'b0, busy}, 32'd0);

    // sra by shamt = 4 on 0x80000000.
    applyStimulus(6'h03, 5'd4, 32'h0000_0003, 32'h8000_0000);
    checkOutput("sra_alu_op", {29'b0, alu_op}, 32'd5);
    checkOutput("sra_alu_a", alu_a, 32'h8000_0000);
    checkOutput("sra_alu_b", alu_b, 32'h0000_0004);
    step();
    checkOutput("sra_result", out_result, 32'hF800_0000);
    step();

    // srlv uses rs[4:0] = 4.
    applyStimulus(6'h06, 5'd31, 32'h0000_0124, 32'h8000_0000);
    checkOutput("srlv_alu_op", {29'b0, alu_op}, 32'd4);
    checkOutput("srlv_alu_b", alu_b, 32'h0000_0004);
    step();
    checkOutput("srlv_result", out_result, 32'h0800_0000);
    step();

    // Unsupported funct 0x20.
    applyStimulus(6'h20, 5'd0, 32'd5, 32'd5);
    checkOutput("ill_alu_a", alu_a, 32'd0);
    checkOutput("ill_alu_b", alu_b, 32'd0);
    checkOutput("ill_alu_op", {29'b0, alu_op}, 32'd0);
    step();
    checkOutput("ill_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("ill_flag", {31'b0, out_illegal}, 32'd1);
    checkOutput("ill_result", out_result, 32'd0);
    step();

    // subu 3 - 7 under 5 cycles of backpressure, with stray in_valid pulses.
    out_ready = 1'b0;
    applyStimulus(6'h23, 5'd0, 32'd3, 32'd7);
    step();
    funct  = 6'h24;
    rs_val = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("bp_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp_result", out_result, 32'hFFFF_FFFC);
      step();
    end
    in_valid = 1'b0;
    checkOutput("bp_alu_a_held", alu_a, 32'd3);
    checkOutput("bp_alu_op_held", {29'b0, alu_op}, 32'd1);
    out_ready = 1'b1;
    step();
    checkOutput("bp_release", {31'b0, out_valid}, 32'd0);
    checkOutput("bp_release_idle", {31'b0, busy}, 32'd0);

    // Reset asserted while in EXEC discards the operation.
    applyStimulus(6'h21, 5'd0, 32'd10, 32'd20);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_alu_a", alu_a, 32'd0);
    checkOutput("mid_rst_alu_b", alu_b, 32'd0);
    checkOutput("mid_rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    #3 rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      got = got | out_valid;
    end
    checkOutput("mid_rst_no_valid", {31'b0, got}, 32'd0);

    // Back-to-back and/or with in_valid and out_ready held high.
    funct     = 6'h24;
    rs_val    = 32'h0000_F0F0;
    rt_val    = 32'h0000_FF00;
    in_valid  = 1'b1;
    acc0      = -1;
    acc1      = -1;
    got_first = 1'b0;
    first_res = 32'd0;
    for (int i = 0; i < 12 && acc1 < 0; i++) begin
      got = in_ready;
      step();
      if (got) begin
        if (acc0 < 0) begin
          acc0  = i;
          funct = 6'h25;
        end else begin
          acc1     = i;
          in_valid = 1'b0;
        end
      end
      if (out_valid && !got_first) begin
        got_first = 1'b1;
        first_res = out_result;
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_second_accept", {31'b0, acc1 >= 0}, 32'd1);
    checkOutput("b2b_spacing", acc1 - acc0, EXP_SPACING);
    checkOutput("b2b_and_result", first_res, 32'h0000_F000);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      got = out_valid;
    end
    checkOutput("b2b_or_valid", {31'b0, got}, 32'd1);
    checkOutput("b2b_or_result", out_result, 32'h0000_FFF0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
